// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// The round-robin pointer is sized for the largest supported requester count (4),
// so one pointer type serves every legal N_REQ (2..4).
package dpram_arb_pkg;

  localparam int N_REQ_MAX = 4;
  localparam int PTR_W     = $clog2(N_REQ_MAX);

  typedef logic [PTR_W-1:0] rr_ptr_t;

  // Index that follows idx in a ring of n requesters
  function automatic rr_ptr_t rr_next(input rr_ptr_t idx, input int n);
    rr_ptr_t nxt;
    if (int'(idx) + 1 >= n) nxt = '0;
    else                    nxt = idx + rr_ptr_t'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/dpram_arbiter_rr_picker.sv
// Round-robin picker: returns the first asserted request at or after the pointer,
// wrapping around, as both a one-hot grant and a binary index.
module rr_picker
  import dpram_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  rr_ptr_t          i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output rr_ptr_t          o_idx,
  output logic             o_any
);

  int w_bestDist;
  int w_bestIdx;

  // Winner is the requester with the smallest forward distance from the pointer
  always_comb begin
    w_bestDist = N_REQ;
    w_bestIdx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_req[i] && (((i + N_REQ - int'(i_ptr)) % N_REQ) < w_bestDist)) begin
        w_bestDist = (i + N_REQ - int'(i_ptr)) % N_REQ;
        w_bestIdx  = i;
      end
    end
  end

  // Expand the winning index into the grant vector
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = (w_bestDist < N_REQ) && (w_bestIdx == i);
    end
  end

  assign o_idx = rr_ptr_t'(w_bestIdx);
  assign o_any = (w_bestDist < N_REQ);

endmodule

// File: rtl/dpram_arbiter.sv
// Arbiter placing N_REQ requesters onto a simple dual-port RAM
// (port A write-only, port B read-only with one cycle of read latency).
// Writes and reads are arbitrated independently, each with its own round-robin
// pointer, so one write and one read can complete per cycle.
// A read and a write to the same address in the same cycle is a hazard:
//   default build          - the read is held off one cycle and sees the new data
//   DPRAM_ARB_BYPASS_EN    - the read is granted, the RAM read is suppressed and
//                            the write data is forwarded as the response
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic [ADDR_WIDTH-1:0]       ram_addr_a,
  output logic [DATA_WIDTH-1:0]       ram_data_in_a,
  output logic                        ram_we_a,
  output logic                        ram_en_a,
  output logic [ADDR_WIDTH-1:0]       ram_addr_b,
  output logic                        ram_en_b,
  input  logic [DATA_WIDTH-1:0]       ram_data_out_b
);

  rr_ptr_t r_wrPtr;
  rr_ptr_t r_rdPtr;
  logic [N_REQ-1:0] r_rspValid;

  logic [N_REQ-1:0] w_wrCand;
  logic [N_REQ-1:0] w_rdCand;
  logic [N_REQ-1:0] w_wrGrant;
  logic [N_REQ-1:0] w_rdGrant;
  rr_ptr_t w_wrIdx;
  rr_ptr_t w_rdIdx;
  logic w_wrAny;
  logic w_rdAny;
  logic [ADDR_WIDTH-1:0] w_wrAddr;
  logic [ADDR_WIDTH-1:0] w_rdAddr;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic w_hazard;
  logic w_rdGo;
  logic w_rdRamEn;

  // Nothing is a candidate while reset is held, so no request is accepted and
  // every RAM enable stays low during reset.
  assign w_wrCand = req_valid &  req_we & {N_REQ{~rst}};
  assign w_rdCand = req_valid & ~req_we & {N_REQ{~rst}};

  rr_picker #(.N_REQ(N_REQ)) u_wrPicker (
    .i_req   (w_wrCand),
    .i_ptr   (r_wrPtr),
    .o_grant (w_wrGrant),
    .o_idx   (w_wrIdx),
    .o_any   (w_wrAny)
  );

  rr_picker #(.N_REQ(N_REQ)) u_rdPicker (
    .i_req   (w_rdCand),
    .i_ptr   (r_rdPtr),
    .o_grant (w_rdGrant),
    .o_idx   (w_rdIdx),
    .o_any   (w_rdAny)
  );

  // Route the winning requester's address and data to each port (zero when idle)
  always_comb begin
    w_wrAddr = '0;
    w_wrData = '0;
    w_rdAddr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_wrGrant[i]) begin
        w_wrAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wrData = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_rdGrant[i]) begin
        w_rdAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_hazard = w_wrAny && w_rdAny && (w_wrAddr == w_rdAddr);

`ifdef DPRAM_ARB_BYPASS_EN
  assign w_rdGo    = w_rdAny;
  assign w_rdRamEn = w_rdAny && !w_hazard;
`else
  assign w_rdGo    = w_rdAny && !w_hazard;
  assign w_rdRamEn = w_rdGo;
`endif

  assign req_ready     = w_wrGrant | (w_rdGrant & {N_REQ{w_rdGo}});
  assign ram_en_a      = w_wrAny;
  assign ram_we_a      = w_wrAny;
  assign ram_addr_a    = w_wrAddr;
  assign ram_data_in_a = w_wrData;
  assign ram_en_b      = w_rdRamEn;
  assign ram_addr_b    = w_rdRamEn ? w_rdAddr : '0;

  // Advance each pointer past the requester it just served; hold when idle or stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrAny) r_wrPtr <= rr_next(w_wrIdx, N_REQ);
      if (w_rdGo)  r_rdPtr <= rr_next(w_rdIdx, N_REQ);
    end
  end

  // Remember who was granted a read so the response lands one cycle later
  always_ff @(posedge clk) begin
    if (rst) r_rspValid <= '0;
    else     r_rspValid <= w_rdGrant & {N_REQ{w_rdGo}};
  end

  // Reset suppresses any response already in flight
  assign rsp_valid = r_rspValid & {N_REQ{~rst}};

`ifdef DPRAM_ARB_BYPASS_EN
  logic                  r_bypSel;
  logic [DATA_WIDTH-1:0] r_bypData;

  // Capture the write data when a read is served from it instead of the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bypSel  <= 1'b0;
      r_bypData <= '0;
    end else begin
      r_bypSel  <= w_rdGo && w_hazard;
      r_bypData <= w_wrData;
    end
  end

  // Response data comes from the forwarding register or the RAM
  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid != '0) rsp_rdata = r_bypSel ? r_bypData : ram_data_out_b;
  end
`else
  // Response data comes from the RAM and is zero whenever no response is valid
  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid != '0) rsp_rdata = ram_data_out_b;
  end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed testbench for dpram_arbiter with a behavioural simple dual-port RAM.
// Expectations for the address-hazard case follow DPRAM_ARB_BYPASS_EN.
module tb_dpram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 2;

  logic           clk;
  logic           rst;
  logic [NR-1:0]    reqValid;
  logic [NR-1:0]    reqWe;
  logic [NR*AW-1:0] reqAddr;
  logic [NR*DW-1:0] reqWdata;
  logic [NR-1:0]    reqReady;
  logic [NR-1:0]    rspValid;
  logic [DW-1:0]    rspRdata;
  logic [AW-1:0]    ramAddrA;
  logic [DW-1:0]    ramDataInA;
  logic             ramWeA;
  logic             ramEnA;
  logic [AW-1:0]    ramAddrB;
  logic             ramEnB;
  logic [DW-1:0]    ramDout;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          memClear;
  logic [DW-1:0] expData [4];

  int nChecks = 0;
  int nFails  = 0;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (reqValid),
    .req_we         (reqWe),
    .req_addr       (reqAddr),
    .req_wdata      (reqWdata),
    .req_ready      (reqReady),
    .rsp_valid      (rspValid),
    .rsp_rdata      (rspRdata),
    .ram_addr_a     (ramAddrA),
    .ram_data_in_a  (ramDataInA),
    .ram_we_a       (ramWeA),
    .ram_en_a       (ramEnA),
    .ram_addr_b     (ramAddrB),
    .ram_en_b       (ramEnB),
    .ram_data_out_b (ramDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write on port A, registered read on port B
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      ramDout <= '0;
    end else begin
      if (ramEnA && ramWeA) mem[ramAddrA] <= ramDataInA;
      if (ramEnB) ramDout <= mem[ramAddrB];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[idx]          = v;
    reqWe[idx]             = we;
    reqAddr[idx*AW +: AW]  = a;
    reqWdata[idx*DW +: DW] = d;
  endtask

  task automatic clearReqs();
    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    expData[0] = 8'h00;
    expData[1] = 8'h11;
    expData[2] = 8'hCC;
    expData[3] = 8'h55;
    rst      = 1'b1;
    memClear = 1'b1;
    clearReqs();
    step();
    step();

    // Reset state, with a write presented to prove nothing is accepted
    applyStimulus(0, 1'b1, 1'b1, 4'd5, 8'h77);
    #1;
    checkOutput("rstRspValid", rspValid, 2'b00);
    checkOutput("rstRspRdata", rspRdata, 8'h00);
    checkOutput("rstEnA", ramEnA, 1'b0);
    checkOutput("rstEnB", ramEnB, 1'b0);
    checkOutput("rstReady", reqReady, 2'b00);
    clearReqs();
    rst      = 1'b0;
    memClear = 1'b0;
    step();

    // Two writers contend: grants alternate 0,1,0,1
    applyStimulus(0, 1'b1, 1'b1, 4'd1, 8'h11);
    applyStimulus(1, 1'b1, 1'b1, 4'd2, 8'h22);
    #1;
    for (int c = 0; c < 4; c++) begin
      checkOutput("wrAltReady", reqReady, (c % 2 == 1) ? 2'b10 : 2'b01);
      checkOutput("wrAltAddr", ramAddrA, (c % 2 == 1) ? 4'd2 : 4'd1);
      checkOutput("wrAltData", ramDataInA, (c % 2 == 1) ? 8'h22 : 8'h11);
      checkOutput("wrAltWe", {ramEnA, ramWeA}, 2'b11);
      step();
    end
    clearReqs();

    // Write 0xAA to addr 4, then read it back through requester 1
    applyStimulus(0, 1'b1, 1'b1, 4'd4, 8'hAA);
    #1;
    checkOutput("wrAAReady", reqReady, 2'b01);
    checkOutput("wrAAAddr", ramAddrA, 4'd4);
    checkOutput("wrAAEnB", ramEnB, 1'b0);
    step();
    clearReqs();
    applyStimulus(1, 1'b1, 1'b0, 4'd4, 8'h00);
    #1;
    checkOutput("rdAAReady", reqReady, 2'b10);
    checkOutput("rdAAEnB", ramEnB, 1'b1);
    checkOutput("rdAAAddrB", ramAddrB, 4'd4);
    checkOutput("rdAAEnA", ramEnA, 1'b0);
    step();
    clearReqs();
    #1;
    checkOutput("rdAARspValid", rspValid, 2'b10);
    checkOutput("rdAARspData", rspRdata, 8'hAA);

    // Independent write and read in the same cycle
    applyStimulus(0, 1'b1, 1'b1, 4'd3, 8'h55);
    applyStimulus(1, 1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    checkOutput("wrRdReady", reqReady, 2'b11);
    checkOutput("wrRdEnA", ramEnA, 1'b1);
    checkOutput("wrRdEnB", ramEnB, 1'b1);
    checkOutput("wrRdAddrB", ramAddrB, 4'd7);
    step();
    clearReqs();
    #1;
    checkOutput("wrRdRspValid", rspValid, 2'b10);
    checkOutput("wrRdRspData", rspRdata, 8'h00);

    // Same-address write and read
    applyStimulus(0, 1'b1, 1'b1, 4'd2, 8'hCC);
    applyStimulus(1, 1'b1, 1'b0, 4'd2, 8'h00);
    #1;
`ifdef DPRAM_ARB_BYPASS_EN
    checkOutput("hazReady", reqReady, 2'b11);
    checkOutput("hazEnB", ramEnB, 1'b0);
    checkOutput("hazEnA", ramEnA, 1'b1);
    step();
    clearReqs();
    #1;
`else
    checkOutput("hazReady", reqReady, 2'b01);
    checkOutput("hazEnB", ramEnB, 1'b0);
    checkOutput("hazEnA", ramEnA, 1'b1);
    step();
    applyStimulus(0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    checkOutput("hazRetryReady", reqReady, 2'b10);
    checkOutput("hazRetryEnB", ramEnB, 1'b1);
    checkOutput("hazRetryAddrB", ramAddrB, 4'd2);
    checkOutput("hazStallRsp", rspValid, 2'b00);
    step();
    clearReqs();
    #1;
`endif
    checkOutput("hazRspValid", rspValid, 2'b10);
    checkOutput("hazRspData", rspRdata, 8'hCC);

    // Reset the cycle after a read is accepted (leaves rdPtr=1, wrPtr=1 beforehand)
    applyStimulus(0, 1'b1, 1'b0, 4'd4, 8'h00);
    #1;
    checkOutput("preRstReady", reqReady, 2'b01);
    step();
    clearReqs();
    rst = 1'b1;
    #1;
    checkOutput("midRstRspValid", rspValid, 2'b00);
    checkOutput("midRstRspData", rspRdata, 8'h00);
    checkOutput("midRstEnA", ramEnA, 1'b0);
    checkOutput("midRstEnB", ramEnB, 1'b0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("postRstRspValid", rspValid, 2'b00);

    // Pointers are back at 0: requester 0 wins both ports first
    applyStimulus(0, 1'b1, 1'b1, 4'd5, 8'h5A);
    applyStimulus(1, 1'b1, 1'b1, 4'd6, 8'h6B);
    #1;
    checkOutput("postRstWrReady", reqReady, 2'b01);
    checkOutput("postRstWrAddr", ramAddrA, 4'd5);
    step();
    clearReqs();
    applyStimulus(0, 1'b1, 1'b0, 4'd8, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 4'd9, 8'h00);
    #1;
    checkOutput("postRstRdReady", reqReady, 2'b01);
    checkOutput("postRstRdAddr", ramAddrB, 4'd8);
    step();
    clearReqs();
    #1;
    checkOutput("postRstRdRsp", rspValid, 2'b01);

    // Back-to-back reads by requester 0 over addrs 0..3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b0, AW'(i), 8'h00);
      #1;
      checkOutput("b2bReady", reqReady, 2'b01);
      checkOutput("b2bAddrB", ramAddrB, i);
      step();
      checkOutput("b2bRspValid", rspValid, 2'b01);
      checkOutput("b2bRspData", rspRdata, expData[i]);
    end
    clearReqs();
    step();
    checkOutput("b2bIdleRsp", rspValid, 2'b00);
    checkOutput("b2bIdleData", rspRdata, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
